// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - IF/ID/EX/MEM/WB sequencing FSM for the multi-cycle RV32I core
module multi_cycle_control_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_control,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       is_ecall,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] A_PC     = 2'b00;
    localparam logic [1:0] A_CURPC  = 2'b01;
    localparam logic [1:0] A_RS1    = 2'b10;
    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_FOUR   = 2'b01;
    localparam logic [1:0] B_IMM    = 2'b10;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = S_IF;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = A_PC;
        alu_src_b     = B_RS2;
        alu_control   = 1'b0;
        mem_to_reg    = 2'b00;
        reg_write     = 1'b0;
        is_ecall      = 1'b0;
        halted        = 1'b0;

        case (state)
            S_IF: begin
                mem_read    = 1'b1;
                alu_src_b   = B_FOUR;
                alu_control = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_ID;
                end else begin
                    next_state = S_IF;
                end
            end
            S_ID: begin
                // Precompute the branch/JAL target into ALUOut while decoding.
                alu_src_a   = A_CURPC;
                alu_src_b   = B_IMM;
                alu_control = 1'b1;
                case (opcode)
                    OP_ECALL: begin
                        is_ecall   = 1'b1;
                        next_state = halt_req ? S_HALT : S_IF;
                    end
                    OP_R, OP_I, OP_LOAD, OP_STORE,
                    OP_BRANCH, OP_JAL, OP_JALR: next_state = S_EX;
                    default: next_state = S_IF;
                endcase
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a  = A_RS1;
                        next_state = S_WB;
                    end
                    OP_I: begin
                        alu_src_a  = A_RS1;
                        alu_src_b  = B_IMM;
                        next_state = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a   = A_RS1;
                        alu_src_b   = B_IMM;
                        alu_control = 1'b1;
                        next_state  = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a     = A_RS1;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        next_state    = S_IF;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_source  = 1'b1;
                        next_state = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_a   = A_RS1;
                        alu_src_b   = B_IMM;
                        alu_control = 1'b1;
                        pc_write    = 1'b1;
                        next_state  = S_WB;
                    end
                    default: next_state = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        mem_read   = 1'b1;
                        next_state = mem_ready ? S_WB : S_MEM;
                    end
                    OP_STORE: begin
                        mem_write  = 1'b1;
                        next_state = mem_ready ? S_IF : S_MEM;
                    end
                    default: next_state = S_IF;
                endcase
            end
            S_WB: begin
                reg_write = 1'b1;
                case (opcode)
                    OP_LOAD: mem_to_reg = 2'b01;
                    OP_JAL, OP_JALR: begin
                        // Link value cur_pc+4 comes straight off the ALU.
                        mem_to_reg  = 2'b10;
                        alu_src_a   = A_CURPC;
                        alu_src_b   = B_FOUR;
                        alu_control = 1'b1;
                    end
                    default: mem_to_reg = 2'b00;
                endcase
                next_state = S_IF;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_IF;
        endcase

        // Strobes must drop the moment reset asserts, not at the next edge.
        if (!reset_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            alu_src_a     = A_PC;
            alu_src_b     = B_RS2;
            alu_control   = 1'b0;
            mem_to_reg    = 2'b00;
            reg_write     = 1'b0;
            is_ecall      = 1'b0;
            halted        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb/tb_multi_cycle_control_unit.sv - scoreboard bench for multi_cycle_control_unit
module tb_multi_cycle_control_unit;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_control;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       is_ecall;
        logic       halted;
    } ctl_t;

    typedef struct {
        ctl_t  c;
        string tag;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                   K_JAL = 5, K_JALR = 6, K_ECALL = 7, K_NOP = 8;

    logic       clk;
    logic       reset_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       halt_req;
    logic       pc_write, pc_write_cond, pc_source, i_or_d;
    logic       mem_read, mem_write, ir_write, alu_control;
    logic [1:0] alu_src_a, alu_src_b, mem_to_reg;
    logic       reg_write, is_ecall, halted;
    ctl_t       act;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    multi_cycle_control_unit dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .is_ecall(is_ecall), .halted(halted)
    );

    assign act = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, alu_src_a, alu_src_b, alu_control, mem_to_reg,
                  reg_write, is_ecall, halted};

    // Negedge falls first so each pushed expectation is sampled mid-cycle.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                if (act !== e.c) begin
                    bad++;
                    $display("FAIL %s at %0t: got=%05h expected=%05h", e.tag, $time, act, e.c);
                end
            end
        end
    end

    function automatic logic [6:0] op_of(input int k);
        logic [6:0] illegal [5];
        illegal = '{7'h37, 7'h17, 7'h0F, 7'h00, 7'h7F};
        case (k)
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            K_ECALL: return 7'b1110011;
            default: return illegal[$urandom_range(0, 4)];
        endcase
    endfunction

    task automatic step(input ctl_t c, input string tag);
        exp_t e;
        e.c   = c;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            opcode    = 7'($urandom);
            mem_ready = 1'($urandom);
            halt_req  = 1'($urandom);
            step('0, "reset");
        end
        reset_n = 1'b1;
    endtask

    // Expected per-cycle control words derived from the instruction's phase list.
    task automatic run_instr(input int k, input int if_wait, input int mem_wait,
                             input int abort_at, input bit hreq);
        ctl_t       e;
        logic [6:0] op;
        op = op_of(k);

        e = '0;
        e.mem_read    = 1'b1;
        e.alu_src_b   = 2'b01;
        e.alu_control = 1'b1;
        for (int i = 0; i < if_wait; i++) begin
            opcode = 7'($urandom); mem_ready = 1'b0; halt_req = 1'($urandom);
            step(e, "if_wait");
        end
        opcode = 7'($urandom); mem_ready = 1'b1; halt_req = 1'($urandom);
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        step(e, "if_done");

        opcode    = op;
        mem_ready = 1'($urandom);
        halt_req  = (k == K_ECALL) ? hreq : 1'($urandom);
        e = '0;
        e.alu_src_a   = 2'b01;
        e.alu_src_b   = 2'b10;
        e.alu_control = 1'b1;
        e.is_ecall    = (k == K_ECALL);
        step(e, "id");

        if (k == K_ECALL && hreq) begin
            for (int i = 0; i < 4; i++) begin
                opcode = 7'($urandom); mem_ready = 1'($urandom); halt_req = 1'($urandom);
                e = '0;
                e.halted = 1'b1;
                step(e, "halt");
            end
            return;
        end
        if (k == K_ECALL || k == K_NOP) return;

        mem_ready = 1'($urandom);
        halt_req  = 1'($urandom);
        e = '0;
        case (k)
            K_R:  e.alu_src_a = 2'b10;
            K_I:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; end
            K_LD, K_ST: begin
                e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; e.alu_control = 1'b1;
            end
            K_BR: begin
                e.alu_src_a = 2'b10; e.pc_write_cond = 1'b1; e.pc_source = 1'b1;
            end
            K_JAL: begin e.pc_write = 1'b1; e.pc_source = 1'b1; end
            K_JALR: begin
                e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; e.alu_control = 1'b1;
                e.pc_write = 1'b1;
            end
            default: ;
        endcase
        step(e, "ex");
        if (k == K_BR) return;

        if (k == K_LD || k == K_ST) begin
            e = '0;
            e.i_or_d    = 1'b1;
            e.mem_read  = (k == K_LD);
            e.mem_write = (k == K_ST);
            for (int i = 0; i < mem_wait; i++) begin
                if (i == abort_at) begin
                    do_reset(2);
                    return;
                end
                halt_req = 1'($urandom); mem_ready = 1'b0;
                step(e, "mem_wait");
            end
            halt_req = 1'($urandom); mem_ready = 1'b1;
            step(e, "mem_done");
            if (k == K_ST) return;
        end

        mem_ready = 1'($urandom);
        halt_req  = 1'($urandom);
        e = '0;
        e.reg_write = 1'b1;
        if (k == K_LD) begin
            e.mem_to_reg = 2'b01;
        end else if (k == K_JAL || k == K_JALR) begin
            e.mem_to_reg  = 2'b10;
            e.alu_src_a   = 2'b01;
            e.alu_src_b   = 2'b01;
            e.alu_control = 1'b1;
        end
        step(e, "wb");
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = '0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        do_reset(3);

        run_instr(K_R,     0, 0, -1, 1'b0);
        run_instr(K_LD,    2, 2, -1, 1'b0);
        run_instr(K_ST,    0, 3, -1, 1'b0);
        run_instr(K_BR,    0, 0, -1, 1'b0);
        run_instr(K_JALR,  0, 0, -1, 1'b0);
        run_instr(K_ECALL, 0, 0, -1, 1'b0);
        run_instr(K_NOP,   1, 0, -1, 1'b0);
        run_instr(K_I,     0, 0, -1, 1'b0);
        run_instr(K_JAL,   0, 0, -1, 1'b0);
        run_instr(K_ST,    0, 3,  1, 1'b0);
        run_instr(K_LD,    0, 2,  0, 1'b0);
        run_instr(K_ECALL, 0, 0, -1, 1'b1);
        do_reset(2);

        for (int n = 0; n < 150; n++) begin
            int k, iw, mw, ab;
            bit hr;
            k  = $urandom_range(0, 8);
            iw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            hr = (k == K_ECALL) && ($urandom_range(0, 3) == 0);
            ab = ((k == K_LD || k == K_ST) && mw > 0 && $urandom_range(0, 7) == 0)
                 ? $urandom_range(0, mw - 1) : -1;
            run_instr(k, iw, mw, ab, hr);
            if (hr) do_reset($urandom_range(1, 3));
        end

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
